// File: rtl/dmem_responder.sv
// Byte-addressed RV32 data-memory responder: load extension, store lane merge, fault checks, wait states.
// Optional power-up pattern fill is enabled with `define DMEM_INIT_PATTERN_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
`ifdef DMEM_INIT_PATTERN_EN
    INIT,
`endif
    IDLE,
    WAIT,
    RESP
  } state_t;

  logic [31:0] r_mem [DEPTH_WORDS];
  state_t      r_state, w_stateNext;
  logic [3:0]  r_cnt, w_cntNext;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_hs, w_err, w_outOfRange, w_misaligned, w_badOp;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdataRep, w_word, w_shifted, w_loadVal;

`ifdef DMEM_INIT_PATTERN_EN
  logic [AW-1:0] r_initIdx;
  logic [7:0]    w_initBase;
  logic [31:0]   w_initWord;

  // Byte k of memory holds k[7:0]; the low two address bits are zero for the base.
  assign w_initBase = 8'({r_initIdx, 2'b00});
  assign w_initWord = {w_initBase | 8'd3, w_initBase | 8'd2, w_initBase | 8'd1, w_initBase};

  always_ff @(posedge clk) begin
    if (reset)
      r_initIdx <= '0;
    else if (r_state == INIT)
      r_initIdx <= (r_initIdx == AW'(DEPTH_WORDS - 1)) ? '0 : r_initIdx + 1'b1;
  end
`endif

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_hs      = req_valid & req_ready & ~reset;
  assign w_idx     = req_addr[AW+1:2];

  always_comb begin
    w_outOfRange = ({1'b0, req_addr} >= BYTE_CAP);
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    // Stores only allow b/h/w; loads reject the three unassigned encodings.
    w_badOp      = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                          : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
    w_err        = w_outOfRange | w_misaligned | w_badOp;
  end

  always_comb begin
    w_be       = 4'b1111;
    w_wdataRep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be       = 4'b0001 << req_addr[1:0];
        w_wdataRep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be       = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdataRep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_word    = r_mem[w_idx];
    w_shifted = w_word >> {req_addr[1:0], 3'b000};
    case (req_funct3)
      3'b000:  w_loadVal = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_loadVal = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_loadVal = {24'd0, w_shifted[7:0]};
      3'b101:  w_loadVal = {16'd0, w_shifted[15:0]};
      default: w_loadVal = w_shifted;
    endcase
  end

  // Memory has no reset; only the pattern sweep or a fault-free store writes it.
  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_PATTERN_EN
    if (r_state == INIT)
      r_mem[r_initIdx] <= w_initWord;
    else
`endif
    if (w_hs && req_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdataRep[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_INIT_PATTERN_EN
      r_state <= INIT;
`else
      r_state <= IDLE;
`endif
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
`ifdef DMEM_INIT_PATTERN_EN
      INIT: if (r_initIdx == AW'(DEPTH_WORDS - 1)) w_stateNext = IDLE;
`endif
      IDLE: begin
        if (w_hs) begin
          if (LATENCY == 0) begin
            w_stateNext = RESP;
          end else begin
            w_stateNext = WAIT;
            w_cntNext   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_stateNext = RESP;
        else               w_cntNext   = r_cnt - 4'd1;
      end
      RESP:    if (rsp_ready) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Response is captured at the handshake so it stays stable through back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_hs) begin
      r_err   <= w_err;
      r_rdata <= (w_err || req_we) ? 32'd0 : w_loadVal;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array model of the memory.
// Works with or without DMEM_INIT_PATTERN_EN defined.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
    bit          seen;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] lastRdata = 32'd0;
  logic        lastErr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void modelInitPattern();
    for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'(i);
  endfunction

  // Access rules expressed on bytes: size, alignment, range, legal opcode, then extension.
  function automatic exp_t modelAccess(input logic we, input logic [31:0] addr,
                                       input logic [2:0] f3, input logic [31:0] wd);
    exp_t        e;
    int          n;
    bit          err;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
    err = (addr >= 32'(DEPTH*4));
    if (we && f3 > 3'd2) err = 1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1;
    if ((addr % n) != 0) err = 1;
    e.rdata = 32'd0;
    e.err   = err;
    e.hs    = 0;
    e.seen  = 0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mdl[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(addr) + i]) << (8*i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Every cycle a response is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL spurious_rsp_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = q[0];
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        if (!e.seen) begin
          checkOutput("rsp_latency", 32'(cyc), 32'(e.hs + 1 + LAT));
          e.seen = 1;
          q[0] = e;
        end
        if (rsp_ready) begin
          lastRdata = rsp_rdata;
          lastErr   = rsp_err;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic waitInitDone();
    int cnt;
    cnt = 0;
    while (cnt < DEPTH + 100) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
    end
`ifdef DMEM_INIT_PATTERN_EN
    checkOutput("init_ready_low_cycles", 32'(cnt), 32'(DEPTH));
    modelInitPattern();
`else
    checkOutput("ready_after_reset", 32'(cnt), 32'd0);
`endif
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] wd, input int holdLow, input bit resetInWait);
    bit   hs;
    exp_t e;
    hs = 0;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    rsp_ready  = (holdLow == 0);
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      if (req_ready) hs = 1;
    end
    if (!hs) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake_timeout: got req_ready 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    e    = modelAccess(we, addr, f3, wd);
    e.hs = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    if (resetInWait) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        checkOutput("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
      end
`ifdef DMEM_INIT_PATTERN_EN
      waitInitDone();
`endif
      return;
    end
    if (holdLow > 0) begin
      hs = 0;
      for (int i = 0; i < 20 && !hs; i++) begin
        @(negedge clk);
        if (rsp_valid) hs = 1;
      end
      for (int i = 0; i < holdLow; i++) begin
        checkOutput("req_ready_during_backpressure", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("req_ready_after_release", 32'(req_ready), 32'd1);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL rsp_timeout: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    int          sel;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rsp_valid_reset", 32'(rsp_valid), 32'd0);
    checkOutput("rsp_rdata_reset", rsp_rdata, 32'd0);
    checkOutput("rsp_err_reset", 32'(rsp_err), 32'd0);
    waitInitDone();
`ifndef DMEM_INIT_PATTERN_EN
    // Without the init sweep, fill memory with the same byte pattern through stores.
    for (int w = 0; w < DEPTH; w++) begin
      wd = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      applyStimulus(1'b1, 32'(4*w), 3'b010, wd, 0, 0);
    end
`endif

    applyStimulus(1'b0, 32'h8, 3'b010, 32'd0, 0, 0);
    checkOutput("lw_0x8", lastRdata, 32'h0B0A0908);
    checkOutput("lw_0x8_err", 32'(lastErr), 32'd0);

    applyStimulus(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0);
    applyStimulus(1'b0, 32'h13, 3'b000, 32'd0, 0, 0);
    checkOutput("lb_0x13", lastRdata, 32'hFFFFFFDE);
    applyStimulus(1'b0, 32'h13, 3'b100, 32'd0, 0, 0);
    checkOutput("lbu_0x13", lastRdata, 32'h000000DE);
    applyStimulus(1'b0, 32'h12, 3'b001, 32'd0, 0, 0);
    checkOutput("lh_0x12", lastRdata, 32'hFFFFDEAD);
    applyStimulus(1'b0, 32'h10, 3'b101, 32'd0, 0, 0);
    checkOutput("lhu_0x10", lastRdata, 32'h0000BEEF);

    applyStimulus(1'b1, 32'h21, 3'b000, 32'hAAAAAA55, 0, 0);
    applyStimulus(1'b0, 32'h20, 3'b010, 32'd0, 0, 0);
    checkOutput("lw_0x20_after_sb", lastRdata, 32'h23225520);

    applyStimulus(1'b1, 32'h21, 3'b001, 32'h00001234, 0, 0);
    checkOutput("sh_misaligned_err", 32'(lastErr), 32'd1);
    checkOutput("sh_misaligned_rdata", lastRdata, 32'd0);
    applyStimulus(1'b0, 32'h20, 3'b010, 32'd0, 0, 0);
    checkOutput("lw_0x20_unchanged", lastRdata, 32'h23225520);

    applyStimulus(1'b0, 32'(DEPTH*4), 3'b010, 32'd0, 0, 0);
    checkOutput("lw_out_of_range_err", 32'(lastErr), 32'd1);
    applyStimulus(1'b0, 32'(DEPTH*4 - 4), 3'b010, 32'd0, 0, 0);
    checkOutput("lw_last_word", lastRdata, 32'hFFFEFDFC);
    applyStimulus(1'b1, 32'h30, 3'b100, 32'h11111111, 0, 0);
    checkOutput("store_funct3_100_err", 32'(lastErr), 32'd1);

    applyStimulus(1'b0, 32'h34, 3'b010, 32'd0, 5, 0);
    checkOutput("lw_0x34_backpressure", lastRdata, 32'h37363534);

    applyStimulus(1'b1, 32'h40, 3'b010, 32'h12345678, 0, 1);
    applyStimulus(1'b0, 32'h40, 3'b010, 32'd0, 0, 0);
`ifdef DMEM_INIT_PATTERN_EN
    checkOutput("lw_0x40_after_reset", lastRdata, 32'h43424140);
`else
    checkOutput("lw_0x40_after_reset", lastRdata, 32'h12345678);
`endif

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'(DEPTH*4 - 8 + $urandom_range(0, 15));
      else               a = 32'($urandom_range(0, 255));
      f3 = 3'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), a, f3, $urandom, $urandom_range(0, 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Byte-addressed data-memory responder serving load/store requests from the pipeline's memory-access stage over a valid/ready request channel and a valid/ready response channel. Performs RV32 load sign/zero extension, store byte-lane merging, alignment and range checking, and inserts a configurable number of wait states. It is the memory-side end of the pipeline's data interface: the stage initiates, this block responds.

## Interface

Parameters:
- DEPTH_WORDS, 1024: memory size in 32-bit words; byte capacity is DEPTH_WORDS*4.
- LATENCY, 0: wait-state cycles between request acceptance and response valid (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access faulted; no memory side effect.

## Operation

- FSM states: INIT (only with the init feature), IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE. A handshake occurs when req_valid & req_ready are both high at a rising edge.
- On handshake:
  - Classify the request.
  - Error when any of the following holds:
    - req_addr >= DEPTH_WORDS*4.
    - Half access with addr[0] = 1.
    - Word access with addr[1:0] != 0.
    - Store with funct3 not in {000, 001, 010}.
    - Load with funct3 in {011, 110, 111}.
  - Non-error store: commit at the handshake edge.
    - Word index is addr[31:2].
    - Byte enables are selected by addr[1:0] and size.
    - Data is replicated to the selected lanes.
  - Non-error load: read the addressed word at the handshake edge.
    - Shift right by 8*addr[1:0].
    - Sign-extend for b/h; zero-extend for bu/hu; no extension for w.
    - Register the result into rsp_rdata.
  - Error: no write; rsp_rdata = 0, rsp_err = 1.
- Next state after handshake: RESP if LATENCY = 0, else WAIT with the counter loaded to LATENCY-1.
- WAIT: decrement the counter each cycle; at counter 0 go to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready. On that edge go to IDLE and clear rsp_valid and rsp_err.
- Ordering: one outstanding request; strictly serialized. A load following a store to the same bytes returns the stored data.
- Unused bits of req_wdata are ignored. Little-endian byte order within a word.

## Timing

- Reset values: req_ready 0 with the init feature, else 1 from the first cycle after reset; rsp_valid 0, rsp_rdata 0, rsp_err 0; counter 0.
- Latency: a handshake in cycle N gives rsp_valid high in cycle N+1+LATENCY.
- Minimum request-to-request spacing: 2+LATENCY cycles when rsp_ready is held high.
- Back-pressure: rsp_ready low holds RESP indefinitely; req_ready stays 0.
- No combinational path from req_* to rsp_*. req_ready depends only on state.
- Reset mid-operation (WAIT or RESP): the pending response is dropped and rsp_valid is 0 the next cycle. A store already committed at its handshake edge remains in memory (unless re-initialized by INIT).
- Boundary: the last valid word (addr DEPTH_WORDS*4-4) is accepted normally; addr DEPTH_WORDS*4 gives an error.

## Configuration

- Macro DMEM_INIT_PATTERN_EN.
- Defined:
  - Reset enters INIT.
  - INIT writes one word per cycle, indices 0..DEPTH_WORDS-1. Byte k of the memory gets k[7:0], so word w = {4w+3, 4w+2, 4w+1, 4w} (each mod 256).
  - req_ready stays 0 for exactly DEPTH_WORDS cycles, then the FSM moves to IDLE.
  - Reset during INIT restarts the sweep from index 0.
- Undefined: INIT state absent; memory contents after power-up are unspecified; reset leaves memory unchanged and enters IDLE.

## Test plan

- Init sweep (macro on, DEPTH_WORDS 1024): req_ready 0 for 1024 cycles after reset; lw 0x8 -> rsp_rdata 0x0B0A0908, rsp_err 0.
- Extension: sw 0xDEADBEEF @0x10, then:
  - lb 0x13 -> 0xFFFFFFDE.
  - lbu 0x13 -> 0x000000DE.
  - lh 0x12 -> 0xFFFFDEAD.
  - lhu 0x10 -> 0x0000BEEF.
- Byte-lane store: sb 0x55 @0x21 over the init pattern, then lw 0x20 -> 0x23225520.
- Faults: sh @0x21 -> rsp_err 1, rdata 0, and a following lw 0x20 is unchanged; lw @0x1000 (DEPTH_WORDS 1024) -> rsp_err 1; store with funct3 100 -> rsp_err 1.
- Latency/back-pressure (LATENCY 2): handshake in cycle 0 -> rsp_valid in cycle 3. Holding rsp_ready low for 5 cycles keeps rsp_valid, rsp_rdata and rsp_err constant and req_ready 0; release -> req_ready 1 the cycle after.
- Reset in WAIT: assert reset in cycle 1 after a handshake -> rsp_valid never rises. With the macro off, a store issued before the reset is still read back afterwards.
